// File: rtl/credential_pkg.sv
// Shared definitions for keypad credential entry and the unlocker.
package credential_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        FULL,
        LOCKOUT
    } entry_state_t;

    localparam int DIGITS_PER_FIELD = 4;
    localparam int FIELD_COUNT      = 8;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous restart, enable and terminal-compare flag.
module cycle_timer #(
    parameter int CNT_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cmp,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == i_cmp);

endmodule

// File: rtl/credential_entry_ctrl.sv
// Keypad entry sequencer: fills user/pass nibbles, idle timeout, flag handshake
// and timed lockout after the third failed login.
module credential_entry_ctrl
    import credential_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int LOCKOUT_CYC = 500_000_000,
    parameter int CNT_W       = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear_btn,
    input  logic       reset_count,
    input  logic       flag,
    input  logic       flag_select,
    output logic       flag_resolve,
    output logic [3:0] user0,
    output logic [3:0] user1,
    output logic [3:0] user2,
    output logic [3:0] user3,
    output logic [3:0] pass0,
    output logic [3:0] pass1,
    output logic [3:0] pass2,
    output logic [3:0] pass3,
    output logic [3:0] input_count,
    output logic       lockout
);

    localparam logic [CNT_W-1:0] TO_CMP = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LO_CMP = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic             TO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [3:0]       LAST   = 4'(FIELD_COUNT - 1);

    entry_state_t r_state;
    entry_state_t w_state_nxt;
    nibble_t      r_user [DIGITS_PER_FIELD];
    nibble_t      r_pass [DIGITS_PER_FIELD];
    logic [3:0]   r_count;
    logic         r_lockout;
    logic         r_flag_resolve;

    logic             w_accept;
    logic             w_wipe;
    logic             w_lock_nxt;
    logic             w_resolve_nxt;
    logic             w_lock_done;
    logic             w_hit;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_cmp;

    // flag is deliberately blind on the cycle the ack pulse is visible
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_wipe        = 1'b0;
        w_lock_nxt    = r_lockout;
        w_resolve_nxt = 1'b0;
        w_lock_done   = 1'b0;
        unique case (r_state)
            LOCKOUT: begin
                if (w_hit) begin
                    w_lock_done   = 1'b1;
                    w_state_nxt   = IDLE;
                    w_lock_nxt    = 1'b0;
                    w_resolve_nxt = 1'b1;
                end
            end
            IDLE, ENTRY, FULL: begin
                if (flag && !r_flag_resolve) begin
                    w_wipe = 1'b1;
                    if (flag_select) begin
                        w_state_nxt = LOCKOUT;
                        w_lock_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_resolve_nxt = 1'b1;
                    end
                end else if (reset_count || clear_btn ||
                             (TO_EN && w_hit && r_state != IDLE)) begin
                    w_wipe      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (digit_valid && r_state != FULL) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_count == LAST) ? FULL : ENTRY;
                end
            end
        endcase
    end

    assign w_cmp     = (r_state == LOCKOUT) ? LO_CMP : TO_CMP;
    assign w_tmr_en  = (r_state != IDLE);
    assign w_tmr_clr = (r_state == IDLE) || w_accept || w_wipe || w_lock_done;

    cycle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .i_cmp (w_cmp),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_lockout      <= 1'b0;
            r_flag_resolve <= 1'b0;
            for (int i = 0; i < DIGITS_PER_FIELD; i++) begin
                r_user[i] <= '0;
                r_pass[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_lockout      <= w_lock_nxt;
            r_flag_resolve <= w_resolve_nxt;
            if (w_wipe) begin
                r_count <= '0;
                for (int i = 0; i < DIGITS_PER_FIELD; i++) begin
                    r_user[i] <= '0;
                    r_pass[i] <= '0;
                end
            end else if (w_accept) begin
                if (r_count[2]) begin
                    r_pass[r_count[1:0]] <= digit;
                end else begin
                    r_user[r_count[1:0]] <= digit;
                end
                r_count <= r_count + 4'd1;
            end
        end
    end

    assign user0        = r_user[0];
    assign user1        = r_user[1];
    assign user2        = r_user[2];
    assign user3        = r_user[3];
    assign pass0        = r_pass[0];
    assign pass1        = r_pass[1];
    assign pass2        = r_pass[2];
    assign pass3        = r_pass[3];
    assign input_count  = r_count;
    assign lockout      = r_lockout;
    assign flag_resolve = r_flag_resolve;

endmodule
